mem_bist_ctrl: RTL and testbench

//  Parametrised, synthesisable memory self-test engine. Drives a single-port synchronous memory

---
 rtl/mem_bist_ctrl_if.sv | 35 +++
 rtl/mem_bist_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bist_ctrl_if.sv
// Memory-side bus of the BIST engine.
//   master : BIST controller (drives strobes, address, write data; receives read data)
//   slave  : memory or memory model (receives strobes, drives read data)
// Signals:
//   mem_write    write strobe
//   mem_read     read strobe
//   mem_adder    address
//   mem_data_in  write data to memory
//   mem_data_out read data from memory
interface mem_bist_ctrl_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
);
  logic              mem_write;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_adder;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  modport master (
    output mem_write,
    output mem_read,
    output mem_adder,
    output mem_data_in,
    input  mem_data_out
  );

  modport slave (
    input  mem_write,
    input  mem_read,
    input  mem_adder,
    input  mem_data_in,
    output mem_data_out
  );
endinterface

// File: rtl/mem_bist_ctrl.sv
// Memory self-test engine: writes a selectable pattern to every address, reads every address
// back, compares against the same pattern, counts mismatches (saturating) and records the first
// failing address.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle run request, honoured only in idle or done
//   mode              pattern: 0 zeros, 1 data=addr, 2 checkerboard, 3 ones
//   busy, done, pass  run status; pass is valid from done until the next start
//   err_count         saturating mismatch count
//   first_err_valid   a mismatch has been seen this run
//   first_err_addr    address of the first mismatch
//   mem               memory bus (master side)
module mem_bist_ctrl #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned ERR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic              first_err_valid,
  output logic [ADDR_W-1:0] first_err_addr,
  mem_bist_ctrl_if.master   mem
);

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic                fev_q, fev_d;
  logic [ADDR_W-1:0]   fea_q, fea_d;
  logic                wr_q, wr_d;
  logic                rd_q, rd_d;
  logic [ADDR_W-1:0]   adder_q, adder_d;
  logic [DATA_W-1:0]   din_q, din_d;

  // Read tracking pipe: entry 0 captures the address the memory samples on this edge, the last
  // entry lines up with the returned read data.
  logic [READ_LAT-1:0] pipe_vld_q;
  logic [ADDR_W-1:0]   pipe_addr_q [READ_LAT];

  logic                mismatch;

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] p;
    p = '0;
    case (m)
      2'd0: p = '0;
      2'd1: p = DATA_W'(a);  // zero-extends or truncates
      2'd2: for (int i = 0; i < DATA_W; i++) p[i] = a[0] ^ i[0];
      default: p = '1;
    endcase
    return p;
  endfunction

  assign mismatch = pipe_vld_q[READ_LAT-1] &&
                    (mem.mem_data_out != pattern(mode_q, pipe_addr_q[READ_LAT-1]));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fea_d   = fea_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    adder_d = '0;
    din_d   = '0;

    if (mismatch) begin
      if (err_q != {ERR_W{1'b1}}) err_d = err_q + 1'b1;
      if (!fev_q) begin
        fev_d = 1'b1;
        fea_d = pipe_addr_q[READ_LAT-1];
      end
    end

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StWrite;
          mode_d  = mode;
          pass_d  = 1'b0;
          err_d   = '0;
          fev_d   = 1'b0;
          fea_d   = '0;
          wr_d    = 1'b1;
          din_d   = pattern(mode, '0);
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StWrite: begin
        if (adder_q == '1) begin
          state_d = StRead;
          rd_d    = 1'b1;
        end else begin
          wr_d    = 1'b1;
          adder_d = adder_q + 1'b1;
          din_d   = pattern(mode_q, adder_q + 1'b1);
        end
      end
      StRead: begin
        if (adder_q == '1) begin
          state_d = StDrain;
        end else begin
          rd_d    = 1'b1;
          adder_d = adder_q + 1'b1;
        end
      end
      StDrain: begin
        // err_q is final once the pipe has emptied, so pass can be taken from it directly.
        if (pipe_vld_q == '0) begin
          state_d = StDone;
          pass_d  = (err_q == '0);
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StWrite) || (state_d == StRead) || (state_d == StDrain);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mode_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fea_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      adder_q <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fea_q   <= fea_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      adder_q <= adder_d;
      din_q   <= din_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < READ_LAT; i++) pipe_addr_q[i] <= '0;
    end else begin
      pipe_vld_q[0]  <= rd_q;
      pipe_addr_q[0] <= adder_q;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_addr_q[i] <= pipe_addr_q[i-1];
      end
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_addr  = fea_q;
  assign mem.mem_write   = wr_q;
  assign mem.mem_read    = rd_q;
  assign mem.mem_adder   = adder_q;
  assign mem.mem_data_in = din_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: three instances (READ_LAT=1/ERR_W=8, READ_LAT=3, ERR_W=4) share
// clock, reset, start and mode; each has its own memory model with a selectable fault.
module tb_mem_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  int         fault_sel = 0;  // 0 ideal, 1 bit3 stuck-at-1 at addr 5, 2 inverted read data
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  mem_bist_ctrl_if #(.ADDR_W(5), .DATA_W(8)) m0 ();
  mem_bist_ctrl_if #(.ADDR_W(5), .DATA_W(8)) m3 ();
  mem_bist_ctrl_if #(.ADDR_W(5), .DATA_W(8)) m4 ();

  logic       busy0, done0, pass0, fev0;
  logic [7:0] err0;
  logic [4:0] fea0;
  logic       busy3, done3, pass3, fev3;
  logic [7:0] err3;
  logic [4:0] fea3;
  logic       busy4, done4, pass4, fev4;
  logic [3:0] err4;
  logic [4:0] fea4;

  mem_bist_ctrl #(.ADDR_W(5), .DATA_W(8), .READ_LAT(1), .ERR_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(err0), .first_err_valid(fev0), .first_err_addr(fea0), .mem(m0)
  );
  mem_bist_ctrl #(.ADDR_W(5), .DATA_W(8), .READ_LAT(3), .ERR_W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy3), .done(done3),
    .pass(pass3), .err_count(err3), .first_err_valid(fev3), .first_err_addr(fea3), .mem(m3)
  );
  mem_bist_ctrl #(.ADDR_W(5), .DATA_W(8), .READ_LAT(1), .ERR_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy4), .done(done4),
    .pass(pass4), .err_count(err4), .first_err_valid(fev4), .first_err_addr(fea4), .mem(m4)
  );

  logic [31:0] outs0;
  assign outs0 = {busy0, done0, pass0, err0, fev0, fea0,
                  m0.mem_write, m0.mem_read, m0.mem_adder, m0.mem_data_in};

  // Memory models
  logic [7:0] mem0 [32];
  logic [7:0] mem3 [32];
  logic [7:0] mem4 [32];
  logic [7:0] r3a, r3b;

  function automatic logic [7:0] corrupt(input logic [7:0] d, input logic [4:0] a);
    case (fault_sel)
      1:       return (a == 5'd5) ? (d | 8'h08) : d;
      2:       return ~d;
      default: return d;
    endcase
  endfunction

  always @(posedge clk) begin
    if (m0.mem_write) mem0[m0.mem_adder] <= m0.mem_data_in;
    m0.mem_data_out <= corrupt(mem0[m0.mem_adder], m0.mem_adder);
    if (m4.mem_write) mem4[m4.mem_adder] <= m4.mem_data_in;
    m4.mem_data_out <= corrupt(mem4[m4.mem_adder], m4.mem_adder);
    if (m3.mem_write) mem3[m3.mem_adder] <= m3.mem_data_in;
    r3a             <= corrupt(mem3[m3.mem_adder], m3.mem_adder);
    r3b             <= r3a;
    m3.mem_data_out <= r3b;
  end

  function automatic logic [7:0] exp_pat(input logic [1:0] m, input logic [4:0] a);
    case (m)
      2'd0:    return 8'h00;
      2'd1:    return {3'b000, a};
      2'd2:    return a[0] ? 8'h55 : 8'hAA;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts a run at the current negedge. Latencies are counted in clock edges from the start
  // edge to the edge after which done is visible; -1 means never seen within the budget.
  task automatic run_bist(input logic [1:0] m, input bit need3, input int repulse_at,
                          output int lat0, output int lat3, output logic busy1,
                          output logic done1, output int nwr, output int nrd, output int bad);
    lat0 = -1; lat3 = -1; nwr = 0; nrd = 0; bad = 0; busy1 = 1'b0; done1 = 1'b0;
    mode  = m;
    start = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = (k == repulse_at);
      if (k == 1) begin
        busy1 = busy0;
        done1 = done0;
        mode  = ~m;  // must not affect a run in progress
      end
      if (m0.mem_write) begin
        nwr++;
        if (m0.mem_data_in !== exp_pat(m, m0.mem_adder)) bad++;
      end
      if (m0.mem_read) nrd++;
      if (done0 && lat0 < 0) lat0 = k - 1;
      if (done3 && lat3 < 0) lat3 = k - 1;
      if (lat0 >= 0 && (!need3 || lat3 >= 0)) break;
    end
    mode = m;
  endtask

  int   lat0, lat3, nwr, nrd, bad, extra;
  logic busy1, done1, found;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("reset_outs", outs0, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_outs", outs0, 32'h0);

    // 1: ideal memory, zeros
    fault_sel = 0;
    run_bist(2'd0, 1'b1, 0, lat0, lat3, busy1, done1, nwr, nrd, bad);
    check_eq("t1_latency", lat0, 66);
    check_eq("t1_busy_next", busy1, 1);
    check_eq("t1_done_not_early", done1, 0);
    check_eq("t1_writes", nwr, 32);
    check_eq("t1_reads", nrd, 32);
    check_eq("t1_wdata", bad, 0);
    check_eq("t1_pass", pass0, 1);
    check_eq("t1_err", err0, 0);
    check_eq("t1_fev", fev0, 0);

    // 2: data = address, plus READ_LAT=3 instance
    run_bist(2'd1, 1'b1, 0, lat0, lat3, busy1, done1, nwr, nrd, bad);
    check_eq("t2_wdata_eq_addr", bad, 0);
    check_eq("t2_writes", nwr, 32);
    check_eq("t2_pass", pass0, 1);
    check_eq("t2_lat3", lat3, 68);
    check_eq("t2_pass3", pass3, 1);

    // 3: bit 3 stuck-at-1 at address 5
    fault_sel = 1;
    run_bist(2'd1, 1'b1, 0, lat0, lat3, busy1, done1, nwr, nrd, bad);
    check_eq("t3_err", err0, 1);
    check_eq("t3_fea", fea0, 5);
    check_eq("t3_fev", fev0, 1);
    check_eq("t3_pass", pass0, 0);
    check_eq("t3_err_lat3", err3, 1);
    check_eq("t3_fea_lat3", fea3, 5);

    // 4: inverted read data, checkerboard; 4-bit counter saturates
    fault_sel = 2;
    run_bist(2'd2, 1'b1, 0, lat0, lat3, busy1, done1, nwr, nrd, bad);
    check_eq("t4_wdata", bad, 0);
    check_eq("t4_err_sat", err4, 15);
    check_eq("t4_fea", fea4, 0);
    check_eq("t4_fev", fev4, 1);
    check_eq("t4_pass", pass4, 0);
    check_eq("t4_err_8bit", err0, 32);

    // 5: reset during write at address 10, then full run with all-ones
    fault_sel = 0;
    mode  = 2'd1;
    start = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (m0.mem_write && m0.mem_adder == 5'd10) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("t5_reach_addr10", found, 1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_async_reset_outs", outs0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_bist(2'd3, 1'b1, 0, lat0, lat3, busy1, done1, nwr, nrd, bad);
    check_eq("t5_latency", lat0, 66);
    check_eq("t5_wdata", bad, 0);
    check_eq("t5_pass", pass0, 1);

    // 6: start mid-read ignored; start in the done cycle starts a new run
    run_bist(2'd2, 1'b1, 40, lat0, lat3, busy1, done1, nwr, nrd, bad);
    check_eq("t6_latency", lat0, 66);
    extra = 0;
    repeat (60) begin
      @(negedge clk);
      if (done0) extra++;
    end
    check_eq("t6_single_done", extra, 0);
    check_eq("t6_pass_held", pass0, 1);
    run_bist(2'd1, 1'b0, 0, lat0, lat3, busy1, done1, nwr, nrd, bad);
    check_eq("t6_first_latency", lat0, 66);
    run_bist(2'd1, 1'b0, 0, lat0, lat3, busy1, done1, nwr, nrd, bad);
    check_eq("t6_restart_busy", busy1, 1);
    check_eq("t6_restart_done_low", done1, 0);
    check_eq("t6_restart_latency", lat0, 66);
    check_eq("t6_restart_pass", pass0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
